// File: rtl/accum8_pkg.sv
// Shared constants and the state type for the frame accumulator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package accum8_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int COUNT_DEF = 4;

    // ACCUM: collecting samples. DONE: holding a finished frame for the sink.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/accum8_frame_add8_co.sv
// Ripple-carry adder with carry out; carry in is tied low.
// Latency: purely combinational, no registers.
// Backpressure: none (no handshake).
// Ports: a, b (WIDTH operands) -> sum (WIDTH, modulo 2^WIDTH), carry_out.
module add8_co #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    // One full-adder cell per bit; the carry chain ripples LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/accum8_frame.sv
// Sums COUNT unsigned samples per frame (modulo 2^WIDTH) with a sticky carry flag.
// Latency: out_valid rises the cycle after the COUNT-th sample; cadence >= COUNT+1 cycles.
// Backpressure: while a frame waits for out_ready, in_ready is low and no sample is taken.
// Ports: clk, rst_n (async, active low), clr (sync flush, highest priority),
//        in_valid/in_ready/in_data (sample input), out_valid/out_ready/out_sum/out_ovf (frame output).
module accum8_frame
    import accum8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int COUNT = COUNT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam int               CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ovf, ovf_n;
    logic [WIDTH-1:0] sum_q, sum_n;
    logic             ovf_q, ovf_o_n;

    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    add8_co #(
        .WIDTH (WIDTH)
    ) u_add (
        .a         (acc),
        .b         (in_data),
        .sum       (add_sum),
        .carry_out (add_co)
    );

    // Handshake outputs come straight from the state register, so neither
    // in_valid nor out_ready has a combinational path to any output.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf;
        sum_n   = sum_q;
        ovf_o_n = ovf_q;

        if (clr) begin
            // Flush everything, including a frame still waiting in DONE;
            // any handshake in the same cycle is ignored.
            state_n = ACCUM;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            sum_n   = '0;
            ovf_o_n = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc_n = add_sum;
                        ovf_n = ovf | add_co;
                        if (cnt == LAST) begin
                            state_n = DONE;
                            cnt_n   = '0;
                            sum_n   = add_sum;
                            ovf_o_n = ovf | add_co;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Running sum restarts on handoff; the next sample is taken
                    // only from the following cycle (no bypass).
                    if (out_ready) begin
                        state_n = ACCUM;
                        acc_n   = '0;
                        ovf_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
            sum_q <= sum_n;
            ovf_q <= ovf_o_n;
        end
    end

endmodule
